// File: rtl/priority_encoder.sv
// Fixed-priority interrupt encoder: reports the lowest-index active request line
// and a request-present flag, both registered so consumers see clock-aligned values.
module priority_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] interrupts,
    output logic [IDX_W-1:0] y,
    output logic             IRQ
);

    logic [IDX_W-1:0] sel;
    logic             any;
    logic [IDX_W-1:0] y_d, y_q;
    logic             irq_d, irq_q;

    // Walk from the top down so the last hit, the lowest set index, wins.
    always_comb begin
        sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (interrupts[i]) begin
                sel = IDX_W'(i);
            end
        end
        any = |interrupts;
    end

    always_comb begin
        y_d   = sel;
        irq_d = any;
        if (rst) begin
            y_d   = '0;
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        y_q   <= y_d;
        irq_q <= irq_d;
    end

    assign y   = y_q;
    assign IRQ = irq_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: directed scenarios plus randomized
// traffic checked against a first-set-bit search model.
module tb_priority_encoder;

    localparam int WIDTH = 4;
    localparam int IDX_W = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] interrupts;
    logic [IDX_W-1:0] y;
    logic             IRQ;

    int checks = 0;
    int errors = 0;

    priority_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .interrupts (interrupts),
        .y          (y),
        .IRQ        (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of the first set bit scanning upward, -1 when idle.
    function automatic int first_set(input logic [WIDTH-1:0] v);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic logic [IDX_W-1:0] ref_y(input logic [WIDTH-1:0] v);
        int k;
        k = first_set(v);
        return (k < 0) ? '0 : IDX_W'(k);
    endfunction

    function automatic logic ref_irq(input logic [WIDTH-1:0] v);
        return first_set(v) >= 0;
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        interrupts = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (y !== 2'b00 || IRQ !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got y=%b IRQ=%b want y=00 IRQ=0", c, y, IRQ);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (y !== 2'b00 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got y=%b IRQ=%b want y=00 IRQ=1", y, IRQ);
        end
    endtask

    task automatic test_sweep();
        logic [IDX_W-1:0] ey;
        logic             eirq;
        for (int i = 0; i < 16; i++) begin
            interrupts = 4'(i);
            tick();
            if (i == 0)                                   ey = 2'b00;
            else if (i % 2 == 1)                          ey = 2'b00;
            else if (i == 2 || i == 6 || i == 10 || i == 14) ey = 2'b01;
            else if (i == 4 || i == 12)                   ey = 2'b10;
            else                                          ey = 2'b11;
            eirq = (i != 0);
            checks++;
            if (y !== ey || IRQ !== eirq) begin
                errors++;
                $display("FAIL sweep in=%b got y=%b IRQ=%b want y=%b IRQ=%b", 4'(i), y, IRQ, ey, eirq);
            end
            interrupts = '0;
            tick();
        end
    endtask

    task automatic test_contention();
        logic [WIDTH-1:0] pat [3];
        logic [IDX_W-1:0] ey  [3];
        pat[0] = 4'b1110; ey[0] = 2'b01;
        pat[1] = 4'b1100; ey[1] = 2'b10;
        pat[2] = 4'b1000; ey[2] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            interrupts = pat[k];
            tick();
            checks++;
            if (y !== ey[k] || IRQ !== 1'b1) begin
                errors++;
                $display("FAIL contention in=%b got y=%b IRQ=%b want y=%b IRQ=1", pat[k], y, IRQ, ey[k]);
            end
        end
    endtask

    task automatic test_latency();
        interrupts = '0;
        tick();
        #3 interrupts = 4'b0100;
        #2;
        checks++;
        if (y !== 2'b00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL latency_before_edge got y=%b IRQ=%b want y=00 IRQ=0", y, IRQ);
        end
        tick();
        checks++;
        if (y !== 2'b10 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL latency_after_edge got y=%b IRQ=%b want y=10 IRQ=1", y, IRQ);
        end
    endtask

    task automatic test_reset_mid();
        interrupts = 4'b1000;
        tick();
        checks++;
        if (y !== 2'b11 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got y=%b IRQ=%b want y=11 IRQ=1", y, IRQ);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (y !== 2'b00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL midrst_assert got y=%b IRQ=%b want y=00 IRQ=0", y, IRQ);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (y !== 2'b11 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL midrst_release got y=%b IRQ=%b want y=11 IRQ=1", y, IRQ);
        end
    endtask

    task automatic test_idle();
        interrupts = 4'b0010;
        tick();
        checks++;
        if (y !== 2'b01 || IRQ !== 1'b1) begin
            errors++;
            $display("FAIL idle_pre got y=%b IRQ=%b want y=01 IRQ=1", y, IRQ);
        end
        interrupts = '0;
        tick();
        checks++;
        if (y !== 2'b00 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL idle_return got y=%b IRQ=%b want y=00 IRQ=0", y, IRQ);
        end
    endtask

    task automatic test_random();
        logic [IDX_W-1:0] ey;
        logic             eirq;
        for (int n = 0; n < 300; n++) begin
            interrupts = WIDTH'($urandom);
            rst = ($urandom_range(0, 15) == 0);
            if (rst) begin
                ey = '0;
                eirq = 1'b0;
            end else begin
                ey = ref_y(interrupts);
                eirq = ref_irq(interrupts);
            end
            tick();
            checks++;
            if (y !== ey || IRQ !== eirq) begin
                errors++;
                $display("FAIL random n=%0d in=%b rst=%b got y=%b IRQ=%b want y=%b IRQ=%b",
                         n, interrupts, rst, y, IRQ, ey, eirq);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        interrupts = '0;
        test_reset();
        test_sweep();
        test_contention();
        test_latency();
        test_reset_mid();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_encoder.md
Name: priority_encoder

Overview:
- Fixed-priority interrupt encoder for the interrupt controller path.
- Takes a vector of interrupt request lines and reports the index of the highest-priority active line. Bit 0 has the highest priority.
- Raises IRQ whenever any line is active.
- Outputs are registered so the downstream CPU-side logic sees glitch-free, clock-aligned values.

Parameters:
- WIDTH, 4, number of interrupt request lines; must be at least 2.
- IDX_W, 2, width of the encoded index; equals clog2(WIDTH). Legal combinations are the user's responsibility.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- interrupts  input  WIDTH  interrupt request lines, level-sensitive, active-high; bit 0 has the highest priority.
- y  output  IDX_W  index of the highest-priority asserted line (registered).
- IRQ  output  1  high when any interrupt line is asserted (registered).

Behaviour:
- Combinational search:
  - sel = smallest index i with interrupts[i]=1.
  - any = OR-reduction of interrupts.
  - If no bit is set, sel=0 and any=0.
- Registers, updated on each rising edge of clk:
  - If rst=1: y<=0 and IRQ<=0. Reset has priority over the input.
  - Else: y<=sel and IRQ<=any.
- Latency: exactly one clock. A value applied before edge N appears on y/IRQ after edge N and holds until the next edge.
- No enable, no handshake and no sticky or latched pending state. Output follows the input level every cycle.
  - A request deasserted before the next edge is lost; this is intentional.
- Priority encoding for WIDTH=4:
  - xxx1 -> y=00
  - xx10 -> y=01
  - x100 -> y=10
  - 1000 -> y=11
  - 0000 -> y=00, IRQ=0
  - IRQ=1 for every nonzero input.
- Simultaneous requests: lower index always wins; higher-index bits are ignored for y but still contribute to IRQ.
- y=0 is ambiguous between "line 0" and "idle". Consumers must qualify y with IRQ.
- Reset mid-operation: the outputs clear on the first edge with rst=1. Normal encoding resumes on the first edge after rst deasserts, reflecting the input present at that edge.
- Outputs are driven only from flops: no combinational path from interrupts to y/IRQ.
- Implementation uses a generic loop or priority chain parameterized on WIDTH. Do not hard-code a 4-bit case table.

Test Plan:
- Reset: assert rst for 2 cycles with interrupts=4'b1111 -> y=00, IRQ=0 throughout. One edge after deassert -> y=00, IRQ=1.
- Exhaustive sweep: for i=0..15, drive interrupts=i, wait one edge, check the expected values, then drive 0 for one cycle. Expected results:
  - i=0 -> y=00, IRQ=0
  - odd i -> y=00
  - i in {2,6,10,14} -> y=01
  - i in {4,12} -> y=10
  - i=8 -> y=11
  - IRQ=1 for all i>0.
- Priority contention: interrupts=4'b1110 -> y=01, IRQ=1. Then 4'b1100 -> y=10. Then 4'b1000 -> y=11. Each response appears one edge after the stimulus.
- Latency check: change interrupts from 0000 to 0100 mid-cycle -> y/IRQ stay 00/0 until the next rising edge, then become 10/1.
- Reset mid-stream: interrupts=4'b1000 steady with y=11, assert rst for one edge -> y=00, IRQ=0. Deassert rst -> y=11, IRQ=1 on the following edge.
- Return to idle: after 4'b0010, drive 0000 -> y=00, IRQ=0 one edge later.
